// File: rtl/sm_inst_buffer_if.sv
// Fetch/decode side bundle of the per-warp instruction buffer.
// Master drives requests, responses, pops and flushes.
interface sm_inst_buffer_if #(
  parameter int NUM_WARP            = 4,
  parameter int DEPTH_WARP          = 2,
  parameter int INST_WIDTH          = 32,
  parameter int CODE_MEM_ADDR_WIDTH = 32
);
  logic                           code_rd_req_valid_i;
  logic [DEPTH_WARP-1:0]          code_rd_req_wid_i;
  logic                           code_rd_rsp_valid_i;
  logic [DEPTH_WARP-1:0]          code_rd_rsp_wid_i;
  logic [CODE_MEM_ADDR_WIDTH-1:0] code_rd_rsp_addr_i;
  logic [INST_WIDTH-1:0]          code_rd_rsp_data_i;
  logic [NUM_WARP-1:0]            inst_buffer_avail_o;
  logic [NUM_WARP-1:0]            ibuf_rdy_o;
  logic                           dec_pop_i;
  logic [DEPTH_WARP-1:0]          dec_pop_wid_i;
  logic [INST_WIDTH-1:0]          head_inst_o;
  logic [CODE_MEM_ADDR_WIDTH-1:0] head_pc_o;
  logic                           flush_i;
  logic [DEPTH_WARP-1:0]          flush_wid_i;

  modport master (
    output code_rd_req_valid_i, code_rd_req_wid_i,
    output code_rd_rsp_valid_i, code_rd_rsp_wid_i,
    output code_rd_rsp_addr_i, code_rd_rsp_data_i,
    output dec_pop_i, dec_pop_wid_i,
    output flush_i, flush_wid_i,
    input  inst_buffer_avail_o, ibuf_rdy_o,
    input  head_inst_o, head_pc_o
  );

  modport slave (
    input  code_rd_req_valid_i, code_rd_req_wid_i,
    input  code_rd_rsp_valid_i, code_rd_rsp_wid_i,
    input  code_rd_rsp_addr_i, code_rd_rsp_data_i,
    input  dec_pop_i, dec_pop_wid_i,
    input  flush_i, flush_wid_i,
    output inst_buffer_avail_o, ibuf_rdy_o,
    output head_inst_o, head_pc_o
  );
endinterface

// File: rtl/sm_inst_buffer.sv
// Per-warp instruction FIFOs with credit accounting and flush-drop.
// Optional same-cycle response forwarding: define IBUF_BYPASS_EN.
module sm_inst_buffer #(
  parameter int NUM_WARP            = 4,
  parameter int DEPTH_WARP          = 2,
  parameter int IBUF_DEPTH          = 4,
  parameter int INST_WIDTH          = 32,
  parameter int CODE_MEM_ADDR_WIDTH = 32
) (
  input logic            clk,
  input logic            rst_n,
  sm_inst_buffer_if.slave bus
);
  localparam int AW = $clog2(IBUF_DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0] r_wr   [NUM_WARP];
  logic [PW-1:0] r_rd   [NUM_WARP];
  logic [PW-1:0] r_infl [NUM_WARP];
  logic [PW-1:0] r_drop [NUM_WARP];

  logic [INST_WIDTH-1:0] r_inst
    [NUM_WARP][IBUF_DEPTH];
  logic [CODE_MEM_ADDR_WIDTH-1:0] r_pc
    [NUM_WARP][IBUF_DEPTH];

  logic [PW-1:0] w_count    [NUM_WARP];
  logic [PW-1:0] w_infl_nxt [NUM_WARP];
  logic [NUM_WARP-1:0] w_req;
  logic [NUM_WARP-1:0] w_rsp;
  logic [NUM_WARP-1:0] w_pop;
  logic [NUM_WARP-1:0] w_flush;
  logic [NUM_WARP-1:0] w_byp;
  logic [NUM_WARP-1:0] w_wr;
  logic [NUM_WARP-1:0] w_rd_en;
  logic [NUM_WARP-1:0] w_avail;
  logic [NUM_WARP-1:0] w_rdy;

  always_comb begin
    for (int w = 0; w < NUM_WARP; w++) begin
      w_count[w] = r_wr[w] - r_rd[w];
      w_req[w] = bus.code_rd_req_valid_i &&
        (bus.code_rd_req_wid_i == DEPTH_WARP'(w));
      w_rsp[w] = bus.code_rd_rsp_valid_i &&
        (bus.code_rd_rsp_wid_i == DEPTH_WARP'(w));
      w_pop[w] = bus.dec_pop_i &&
        (bus.dec_pop_wid_i == DEPTH_WARP'(w));
      w_flush[w] = bus.flush_i &&
        (bus.flush_wid_i == DEPTH_WARP'(w));
      w_infl_nxt[w] = r_infl[w] + PW'(w_req[w])
        - PW'(w_rsp[w]);
`ifdef IBUF_BYPASS_EN
      w_byp[w] = w_rsp[w] && (r_drop[w] == '0) &&
        (w_count[w] == '0) && !w_flush[w];
`else
      w_byp[w] = 1'b0;
`endif
      // a forwarded entry that is popped at once never lands
      w_wr[w] = w_rsp[w] && (r_drop[w] == '0) &&
        !w_flush[w] && !(w_byp[w] && w_pop[w]);
      w_rd_en[w] = w_pop[w] && (w_count[w] != '0) &&
        !w_flush[w];
      w_avail[w] = ({1'b0, w_count[w]} +
        {1'b0, r_infl[w]}) < (PW + 1)'(IBUF_DEPTH);
      w_rdy[w] = (w_count[w] != '0) || w_byp[w];
    end
  end

  assign bus.inst_buffer_avail_o = w_avail;
  assign bus.ibuf_rdy_o          = w_rdy;

  always_comb begin
    bus.head_inst_o = '0;
    bus.head_pc_o   = '0;
    if (w_count[bus.dec_pop_wid_i] != '0) begin
      bus.head_inst_o = r_inst[bus.dec_pop_wid_i]
        [r_rd[bus.dec_pop_wid_i][AW-1:0]];
      bus.head_pc_o = r_pc[bus.dec_pop_wid_i]
        [r_rd[bus.dec_pop_wid_i][AW-1:0]];
    end
`ifdef IBUF_BYPASS_EN
    else if (w_byp[bus.dec_pop_wid_i]) begin
      bus.head_inst_o = bus.code_rd_rsp_data_i;
      bus.head_pc_o   = bus.code_rd_rsp_addr_i;
    end
`else
    else begin
      bus.head_inst_o = '0;
      bus.head_pc_o   = '0;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int w = 0; w < NUM_WARP; w++) begin
        r_wr[w]   <= '0;
        r_rd[w]   <= '0;
        r_infl[w] <= '0;
        r_drop[w] <= '0;
      end
    end else begin
      for (int w = 0; w < NUM_WARP; w++) begin
        r_infl[w] <= w_infl_nxt[w];
        if (w_flush[w]) begin
          r_wr[w]   <= '0;
          r_rd[w]   <= '0;
          r_drop[w] <= w_infl_nxt[w];
        end else begin
          if (w_wr[w])
            r_wr[w] <= r_wr[w] + PW'(1);
          if (w_rd_en[w])
            r_rd[w] <= r_rd[w] + PW'(1);
          if (w_rsp[w] && (r_drop[w] != '0))
            r_drop[w] <= r_drop[w] - PW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int w = 0; w < NUM_WARP; w++) begin
      if (w_wr[w]) begin
        r_inst[w][r_wr[w][AW-1:0]] <=
          bus.code_rd_rsp_data_i;
        r_pc[w][r_wr[w][AW-1:0]] <=
          bus.code_rd_rsp_addr_i;
      end
    end
  end
endmodule

// File: tb/tb_sm_inst_buffer.sv
// Scoreboard bench for sm_inst_buffer.
// Expected entries are queued per warp on response, checked on pop.
module tb_sm_inst_buffer;
  localparam int NW  = 4;
  localparam int DW  = 2;
  localparam int DEP = 4;
  localparam int IW  = 32;
  localparam int AWD = 32;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  sm_inst_buffer_if #(
    .NUM_WARP(NW), .DEPTH_WARP(DW),
    .INST_WIDTH(IW), .CODE_MEM_ADDR_WIDTH(AWD)
  ) bus ();

  sm_inst_buffer #(
    .NUM_WARP(NW), .DEPTH_WARP(DW), .IBUF_DEPTH(DEP),
    .INST_WIDTH(IW), .CODE_MEM_ADDR_WIDTH(AWD)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [63:0] sb [NW][$];
  int infl_m [NW];
  int drop_m [NW];

  task automatic check(string tag, logic [63:0] obs,
                       logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    bus.code_rd_req_valid_i = 1'b0;
    bus.code_rd_req_wid_i   = '0;
    bus.code_rd_rsp_valid_i = 1'b0;
    bus.code_rd_rsp_wid_i   = '0;
    bus.code_rd_rsp_addr_i  = '0;
    bus.code_rd_rsp_data_i  = '0;
    bus.dec_pop_i           = 1'b0;
    bus.dec_pop_wid_i       = '0;
    bus.flush_i             = 1'b0;
    bus.flush_wid_i         = '0;
  endtask

  task automatic check_state();
    for (int w = 0; w < NW; w++) begin
      check($sformatf("avail%0d", w),
        64'(bus.inst_buffer_avail_o[w]),
        64'((sb[w].size() + infl_m[w]) < DEP));
      check($sformatf("rdy%0d", w),
        64'(bus.ibuf_rdy_o[w]),
        64'(sb[w].size() != 0));
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    clr();
    check_state();
  endtask

  task automatic req(int w);
    bus.code_rd_req_valid_i = 1'b1;
    bus.code_rd_req_wid_i   = DW'(w);
    infl_m[w]++;
  endtask

  task automatic rsp(int w, logic [31:0] pc,
                     logic [31:0] inst);
    bus.code_rd_rsp_valid_i = 1'b1;
    bus.code_rd_rsp_wid_i   = DW'(w);
    bus.code_rd_rsp_addr_i  = pc;
    bus.code_rd_rsp_data_i  = inst;
    infl_m[w]--;
    if (drop_m[w] > 0) drop_m[w]--;
    else sb[w].push_back({pc, inst});
  endtask

  task automatic flush(int w);
    bus.flush_i     = 1'b1;
    bus.flush_wid_i = DW'(w);
    sb[w].delete();
    drop_m[w] = infl_m[w];
  endtask

  task automatic pop(int w);
    logic [63:0] e;
    bus.dec_pop_wid_i = DW'(w);
    bus.dec_pop_i     = 1'b1;
    #1;
    e = (sb[w].size() != 0) ? sb[w][0] : 64'd0;
    check("pop_rdy", 64'(bus.ibuf_rdy_o[w]),
      64'(sb[w].size() != 0));
    check("head", {bus.head_pc_o, bus.head_inst_o}, e);
    if (sb[w].size() != 0) void'(sb[w].pop_front());
  endtask

  always @(negedge clk)
    if (rst_n === 1'b1 && bus.code_rd_req_valid_i)
      check("credit",
        64'(bus.inst_buffer_avail_o[bus.code_rd_req_wid_i]),
        64'd1);

  initial begin
    for (int w = 0; w < NW; w++) begin
      infl_m[w] = 0;
      drop_m[w] = 0;
    end
    clr();
    rst_n = 1'b0;
    #12;
    check("rst_avail", 64'(bus.inst_buffer_avail_o), 64'hF);
    check("rst_rdy", 64'(bus.ibuf_rdy_o), 64'h0);
    check("rst_inst", 64'(bus.head_inst_o), 64'h0);
    check("rst_pc", 64'(bus.head_pc_o), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // warp 1: fill to the credit limit, drain in order
    for (int i = 0; i < 4; i++) begin
      req(1);
      step();
      check("A_avail", 64'(bus.inst_buffer_avail_o[1]),
        64'(i < 3));
    end
    for (int i = 0; i < 4; i++) begin
      rsp(1, 32'h100 + 32'(4 * i), 32'hA000_0000 + 32'(i));
      step();
    end
    check("A_rdy", 64'(bus.ibuf_rdy_o[1]), 64'd1);
    for (int i = 0; i < 4; i++) begin
      pop(1);
      step();
      if (i == 0)
        check("A_avail_pop",
          64'(bus.inst_buffer_avail_o[1]), 64'd1);
    end

    // warp 2: flush with all responses outstanding
    for (int i = 0; i < 4; i++) begin
      req(2);
      step();
    end
    flush(2);
    step();
    for (int i = 0; i < 4; i++) begin
      rsp(2, 32'h200 + 32'(4 * i), 32'hB000_0000 + 32'(i));
      step();
      check("B_rdy", 64'(bus.ibuf_rdy_o[2]), 64'd0);
    end

    // warp 0: flush, pop and response in one cycle
    req(0); step();
    req(0); step();
    rsp(0, 32'h300, 32'hC000_0000); step();
    rsp(0, 32'h304, 32'hC000_0001); step();
    req(0); step();
    pop(0);
    rsp(0, 32'h308, 32'hC000_0002);
    flush(0);
    step();
    req(0); step();
    rsp(0, 32'h30C, 32'hC000_0003); step();
    pop(0); step();

    // warp 3: write and pop on a one-entry FIFO
    req(3); step();
    rsp(3, 32'h400, 32'hD000_0000); step();
    req(3); step();
    pop(3);
    rsp(3, 32'h404, 32'hD000_0001);
    step();
    pop(3); step();

    // cross-warp write and pop in one cycle
    req(1); step();
    req(2); step();
    rsp(1, 32'h600, 32'hE000_0000); step();
    pop(1);
    rsp(2, 32'h700, 32'hF000_0000);
    step();
    pop(2); step();

    // warp 0 empty: response with a same-cycle pop
    req(0); step();
`ifdef IBUF_BYPASS_EN
    bus.code_rd_rsp_valid_i = 1'b1;
    bus.code_rd_rsp_wid_i   = '0;
    bus.code_rd_rsp_addr_i  = 32'h500;
    bus.code_rd_rsp_data_i  = 32'hDEAD_BEEF;
    infl_m[0]--;
    bus.dec_pop_wid_i = '0;
    bus.dec_pop_i     = 1'b1;
    #1;
    check("byp_inst", 64'(bus.head_inst_o),
      64'hDEAD_BEEF);
    check("byp_pc", 64'(bus.head_pc_o), 64'h500);
    check("byp_rdy", 64'(bus.ibuf_rdy_o[0]), 64'd1);
    step();
`else
    rsp(0, 32'h500, 32'hDEAD_BEEF);
    bus.dec_pop_wid_i = '0;
    #1;
    check("nobyp_rdy", 64'(bus.ibuf_rdy_o[0]), 64'd0);
    check("nobyp_inst", 64'(bus.head_inst_o), 64'd0);
    step();
    pop(0);
    step();
`endif
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
      n_cmp, n_bad);
    $finish;
  end
endmodule
